flash_scheduler: RTL and testbench

Sequencing and arbitration controller for the 16-LED bound flasher. It shares one flasher between two requesters with round-robin arbitration, and generates the flasher's step enable from a programmable prescaler. It drives the flasher's `flick` input to launch each pass, and watches the flasher's `LED` bus to count completed passes against a per-request repeat count. It sits between the request sources (button logic, host command) and the flasher instance.

---
 rtl/flash_scheduler_if.sv | 26 ++
 rtl/flash_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_flash_scheduler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_scheduler_if.sv
// Request/flasher-side bus of flash_scheduler: the requester handshake and the
// flasher LED/flick/step_en wiring.
interface flash_scheduler_if;
  logic [1:0]  req;
  logic [3:0]  rep0;
  logic [3:0]  rep1;
  logic [15:0] led;
  logic [1:0]  gnt;
  logic        step_en;
  logic        flick;
  logic        busy;
  logic        done;
  logic        done_id;
  logic        err;
  logic [3:0]  pass_cnt;

  modport master (
    output req, rep0, rep1, led,
    input  gnt, step_en, flick, busy, done, done_id, err, pass_cnt
  );

  modport slave (
    input  req, rep0, rep1, led,
    output gnt, step_en, flick, busy, done, done_id, err, pass_cnt
  );
endinterface

// File: rtl/flash_scheduler.sv
// Shares one bound flasher between two round-robin requesters: prescaled step
// enable, pass launch via flick, and pass counting from the flasher LED bus.
module flash_scheduler #(
  parameter int PRESCALE   = 4,
  parameter int REST_TICKS = 3,
  parameter int START_TMO  = 4
) (
  input logic              clk,
  input logic              rst,
  flash_scheduler_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  localparam logic [7:0]  PS_MAX   = 8'(PRESCALE - 1);
  localparam logic [7:0]  REST_MAX = 8'(REST_TICKS);
  localparam logic [7:0]  TMO_MAX  = 8'(START_TMO);
  localparam logic [15:0] LED_REST = 16'h0001;
  localparam logic [15:0] LED_FULL = 16'hFFFF;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        step_en_q, step_en_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        flick_q, flick_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;
  logic        err_q, err_d;
  logic [3:0]  pass_cnt_q, pass_cnt_d;
  logic [3:0]  rem_q, rem_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        have_ref_q, have_ref_d;
  logic        seen_full_q, seen_full_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  rest_run_q, rest_run_d;
  logic [15:0] led_ref_q, led_ref_d;
  logic        grant_id;
  logic [3:0]  rep_sel;
  logic [7:0]  tmo_inc, rest_inc;
  logic        tick;

  assign tick = step_en_q;

  always_comb begin
    cnt_d       = (cnt_q == PS_MAX) ? 8'd0 : cnt_q + 8'd1;
    step_en_d   = (cnt_d == PS_MAX);
    state_d     = state_q;
    gnt_d       = 2'b00;
    done_d      = 1'b0;
    err_d       = 1'b0;
    done_id_d   = done_id_q;
    pass_cnt_d  = pass_cnt_q;
    rem_d       = rem_q;
    last_d      = last_q;
    owner_d     = owner_q;
    have_ref_d  = have_ref_q;
    seen_full_d = seen_full_q;
    tmo_d       = tmo_q;
    rest_run_d  = rest_run_q;
    led_ref_d   = led_ref_q;
    grant_id    = 1'b0;
    rep_sel     = 4'd0;
    tmo_inc     = tmo_q + 8'd1;
    rest_inc    = rest_run_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        // The cycle right after done is skipped so busy drops before a new grant.
        if (bus.req != 2'b00 && !done_q) begin
          grant_id    = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          rep_sel     = grant_id ? bus.rep1 : bus.rep0;
          gnt_d       = grant_id ? 2'b10 : 2'b01;
          owner_d     = grant_id;
          rem_d       = (rep_sel == 4'd0) ? 4'd1 : rep_sel;
          pass_cnt_d  = 4'd0;
          have_ref_d  = 1'b0;
          tmo_d       = 8'd0;
          seen_full_d = 1'b0;
          rest_run_d  = 8'd0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (have_ref_q && bus.led != led_ref_q) begin
            seen_full_d = 1'b0;
            rest_run_d  = 8'd0;
            state_d     = S_RUN;
          end else begin
            if (!have_ref_q) begin
              led_ref_d  = bus.led;
              have_ref_d = 1'b1;
            end
            tmo_d = tmo_inc;
            if (tmo_inc == TMO_MAX) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_RUN: begin
        if (tick) begin
          if (bus.led == LED_FULL) seen_full_d = 1'b1;
          if (bus.led == LED_REST) begin
            if (rest_inc == REST_MAX && seen_full_q) begin
              pass_cnt_d  = pass_cnt_q + 4'd1;
              rem_d       = rem_q - 4'd1;
              seen_full_d = 1'b0;
              rest_run_d  = 8'd0;
              have_ref_d  = 1'b0;
              tmo_d       = 8'd0;
              state_d     = (rem_q == 4'd1) ? S_DONE : S_START;
            end else begin
              rest_run_d = rest_inc;
            end
          end else begin
            rest_run_d = 8'd0;
          end
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        done_id_d = owner_q;
        last_d    = owner_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    flick_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      step_en_q   <= 1'b0;
      gnt_q       <= 2'b00;
      flick_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      err_q       <= 1'b0;
      pass_cnt_q  <= 4'd0;
      rem_q       <= 4'd0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      have_ref_q  <= 1'b0;
      seen_full_q <= 1'b0;
      tmo_q       <= 8'd0;
      rest_run_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_en_q   <= step_en_d;
      gnt_q       <= gnt_d;
      flick_q     <= flick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      err_q       <= err_d;
      pass_cnt_q  <= pass_cnt_d;
      rem_q       <= rem_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      have_ref_q  <= have_ref_d;
      seen_full_q <= seen_full_d;
      tmo_q       <= tmo_d;
      rest_run_q  <= rest_run_d;
    end
  end

  // Reference pattern is only meaningful once have_ref_q is set.
  always_ff @(posedge clk) begin
    led_ref_q <= led_ref_d;
  end

  assign bus.gnt      = gnt_q;
  assign bus.step_en  = step_en_q;
  assign bus.flick    = flick_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.done_id  = done_id_q;
  assign bus.err      = err_q;
  assign bus.pass_cnt = pass_cnt_q;
endmodule

// File: tb/tb_flash_scheduler.sv
// Bench for flash_scheduler: two instances (PRESCALE 4 and 1) each driving a
// behavioural bound-flasher model, checked against a grant/pass reference model.
module tb_flash_scheduler;
  localparam int TMO            = 4;
  localparam int REST           = 3;
  // Ticks per pass with the flasher model: 2 in START, 14 rising, 14 falling, REST at rest.
  localparam int TICKS_PER_PASS = 2 + 14 + 14 + REST;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flash_scheduler_if bif0 ();
  flash_scheduler_if bif1 ();

  flash_scheduler #(.PRESCALE(4), .REST_TICKS(REST), .START_TMO(TMO)) dut0 (
    .clk(clk), .rst(rst), .bus(bif0.slave)
  );
  flash_scheduler #(.PRESCALE(1), .REST_TICKS(REST), .START_TMO(TMO)) dut1 (
    .clk(clk), .rst(rst), .bus(bif1.slave)
  );

  // Behavioural flasher: rest shows one LED; flick launches a bar that grows
  // to all 16 LEDs and shrinks back to rest, one LED per step.
  logic [4:0] lvl0, lvl1;
  logic       up0, up1;
  logic       stuck;

  function automatic logic [15:0] bar(input logic [4:0] n);
    logic [16:0] m;
    m = (17'd1 << n) - 17'd1;
    return m[15:0];
  endfunction

  function automatic logic [5:0] fl_next(input logic up, input logic [4:0] lvl, input logic fl);
    if (!up && lvl == 5'd1) return fl ? {1'b1, 5'd2} : {1'b0, 5'd1};
    if (up) return (lvl == 5'd16) ? {1'b0, 5'd15} : {1'b1, lvl + 5'd1};
    return {1'b0, lvl - 5'd1};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl0 <= 5'd1; up0 <= 1'b0;
    end else if (bif0.step_en && !stuck) begin
      {up0, lvl0} <= fl_next(up0, lvl0, bif0.flick);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl1 <= 5'd1; up1 <= 1'b0;
    end else if (bif1.step_en) begin
      {up1, lvl1} <= fl_next(up1, lvl1, bif1.flick);
    end
  end

  assign bif0.led = stuck ? 16'h0001 : bar(lvl0);
  assign bif1.led = bar(lvl1);

  bit         sel;
  logic [1:0] o_gnt;
  logic       o_step, o_flick, o_busy, o_done, o_did, o_err;
  logic [3:0] o_pcnt;
  assign o_gnt   = sel ? bif1.gnt      : bif0.gnt;
  assign o_step  = sel ? bif1.step_en  : bif0.step_en;
  assign o_flick = sel ? bif1.flick    : bif0.flick;
  assign o_busy  = sel ? bif1.busy     : bif0.busy;
  assign o_done  = sel ? bif1.done     : bif0.done;
  assign o_did   = sel ? bif1.done_id  : bif0.done_id;
  assign o_err   = sel ? bif1.err      : bif0.err;
  assign o_pcnt  = sel ? bif1.pass_cnt : bif0.pass_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  bit last_ref [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] r);
    if (sel) bif1.req = r; else bif0.req = r;
  endtask

  task automatic set_rep(input logic [3:0] r0, input logic [3:0] r1);
    if (sel) begin bif1.rep0 = r0; bif1.rep1 = r1; end
    else     begin bif0.rep0 = r0; bif0.rep1 = r1; end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_outs0"}, 32'({bif0.gnt, bif0.step_en, bif0.flick, bif0.busy, bif0.done,
                              bif0.done_id, bif0.err, bif0.pass_cnt}), 32'd0);
    chk({tag, "_outs1"}, 32'({bif1.gnt, bif1.step_en, bif1.flick, bif1.busy, bif1.done,
                              bif1.done_id, bif1.err, bif1.pass_cnt}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b1;
    last_ref[0] = 1'b1;
    last_ref[1] = 1'b1;
  endtask

  // Waits for a grant, then follows it to done or err and checks the whole episode.
  task automatic run_grant(input bit exp_id, input int exp_n, input bit hold, input bit exp_err);
    int waited, cyc, flicks, dones, errs, gnts, ticks, pc_prev;
    bit fl_prev, fin;
    waited = 0;
    do begin @(negedge clk); waited++; end while (o_gnt == 2'b00 && waited < 20);
    chk("gnt_latency", 32'(waited), 32'd1);
    chk("gnt_value", 32'(o_gnt), exp_id ? 32'd2 : 32'd1);
    chk("flick_at_gnt", 32'(o_flick), 32'd1);
    chk("busy_at_gnt", 32'(o_busy), 32'd1);
    chk("pcnt_at_gnt", 32'(o_pcnt), 32'd0);
    if (!hold) drive_req(2'b00);
    flicks = 1; fl_prev = 1'b1; dones = 0; errs = 0; gnts = 0; pc_prev = 0;
    fin = 1'b0; cyc = 0;
    ticks = o_step ? 1 : 0;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (o_flick && !fl_prev) flicks++;
      fl_prev = o_flick;
      if (o_gnt != 2'b00) gnts++;
      if (int'(o_pcnt) != pc_prev) begin
        chk("pcnt_step", 32'(o_pcnt), 32'(pc_prev + 1));
        pc_prev = int'(o_pcnt);
      end
      if (o_busy && int'(o_pcnt) < exp_n && o_step) ticks++;
      if (o_done) begin dones++; fin = 1'b1; end
      if (o_err)  begin errs++;  fin = 1'b1; end
    end
    chk("run_finished", 32'(fin), 32'd1);
    chk("extra_gnt", 32'(gnts), 32'd0);
    if (exp_err) begin
      chk("err_count", 32'(errs), 32'd1);
      chk("done_on_err", 32'(dones), 32'd0);
      chk("busy_at_err", 32'(o_busy), 32'd0);
      chk("flick_at_err", 32'(o_flick), 32'd0);
      chk("pcnt_at_err", 32'(o_pcnt), 32'd0);
      chk("start_ticks", 32'(ticks), 32'(TMO));
      chk("flicks_err", 32'(flicks), 32'd1);
    end else begin
      chk("done_count", 32'(dones), 32'd1);
      chk("err_count", 32'(errs), 32'd0);
      chk("done_id", 32'(o_did), 32'(exp_id));
      chk("pass_cnt", 32'(o_pcnt), 32'(exp_n));
      chk("flick_count", 32'(flicks), 32'(exp_n));
      chk("pass_ticks", 32'(ticks), 32'(TICKS_PER_PASS * exp_n));
      chk("busy_at_done", 32'(o_busy), 32'd1);
      @(negedge clk);
      chk("busy_after_done", 32'(o_busy), 32'd0);
      chk("done_one_cycle", 32'(o_done), 32'd0);
      chk("pcnt_hold", 32'(o_pcnt), 32'(exp_n));
      last_ref[sel] = exp_id;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cnt, pat, r0, r1, n, dones;
    bit id;
    rst = 1'b0; stuck = 1'b0; sel = 1'b0;
    bif0.req = 2'b00; bif0.rep0 = 4'd0; bif0.rep1 = 4'd0;
    bif1.req = 2'b00; bif1.rep0 = 4'd0; bif1.rep1 = 4'd0;
    do_reset();

    // Prescaler period on the PRESCALE=4 instance
    cnt = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (bif0.step_en) cnt++; end
    chk("step_en_rate_ps4", 32'(cnt), 32'd10);

    // Single pass, req held
    set_rep(4'd1, 4'd0);
    drive_req(2'b01);
    run_grant(1'b0, 1, 1'b1, 1'b0);
    drive_req(2'b00);

    // Repeat count 3 on requester 1
    set_rep(4'd0, 4'd3);
    drive_req(2'b10);
    run_grant(1'b1, 3, 1'b0, 1'b0);

    // Random request patterns and repeat counts
    for (int i = 0; i < 6; i++) begin
      pat = int'($urandom_range(1, 3));
      r0  = int'($urandom_range(0, 4));
      r1  = int'($urandom_range(0, 4));
      set_rep(4'(r0), 4'(r1));
      id = (pat == 3) ? !last_ref[0] : (pat == 2);
      n  = id ? r1 : r0;
      if (n == 0) n = 1;
      drive_req(2'(pat));
      run_grant(id, n, 1'b0, 1'b0);
    end

    // Contention from reset: grants alternate starting with requester 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      r0 = int'($urandom_range(0, 3));
      r1 = int'($urandom_range(0, 3));
      set_rep(4'(r0), 4'(r1));
      if (i == 0) drive_req(2'b11);
      n = (i % 2 == 1) ? r1 : r0;
      if (n == 0) n = 1;
      run_grant(1'(i % 2), n, 1'b1, 1'b0);
    end
    drive_req(2'b00);

    // PRESCALE=1 instance: step_en every cycle, rep 0 runs one pass
    sel = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (o_step) cnt++; end
    chk("step_en_rate_ps1", 32'(cnt), 32'd20);
    set_rep(4'd0, 4'd0);
    drive_req(2'b01);
    run_grant(1'b0, 1, 1'b0, 1'b0);
    sel = 1'b0;

    // Start timeout with the flasher stuck at rest
    stuck = 1'b1;
    set_rep(4'd2, 4'd0);
    drive_req(2'b01);
    run_grant(1'b0, 2, 1'b0, 1'b1);
    dones = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (o_done) dones++; end
    chk("no_done_after_err", 32'(dones), 32'd0);
    chk("idle_after_err", 32'(o_busy), 32'd0);
    stuck = 1'b0;

    // Reset asserted during the second of three passes
    set_rep(4'd3, 4'd0);
    drive_req(2'b01);
    k = 0;
    do begin @(negedge clk); k++; end while (o_gnt == 2'b00 && k < 20);
    chk("mid_gnt", 32'(o_gnt), 32'd1);
    drive_req(2'b00);
    k = 0;
    while (!(o_pcnt == 4'd1 && !o_flick) && k < 2000) begin @(negedge clk); k++; end
    chk("mid_in_pass2", 32'(o_pcnt), 32'd1);
    repeat (6) @(negedge clk);
    chk("mid_busy", 32'(o_busy), 32'd1);
    #2 rst = 1'b0;
    #1 chk_reset_outs("async_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_ref[0] = 1'b1;
    last_ref[1] = 1'b1;
    dones = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (o_done) dones++; end
    chk("no_done_after_reset", 32'(dones), 32'd0);
    chk("pcnt_after_reset", 32'(o_pcnt), 32'd0);
    r0 = int'($urandom_range(1, 2));
    set_rep(4'(r0), 4'd0);
    drive_req(2'b01);
    run_grant(1'b0, r0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
